medidor_periodo: RTL

//  Measures the period and high time of a slow external square wave, counted in clk_in cycles.
//  It is the receive-side counterpart of the clock divider: it recovers the divide ratio of a divided clock.

---
 rtl/medidor_periodo.sv | 104 ++++++++++
 1 files changed

// File: rtl/medidor_periodo.sv
// Period and high-time meter for a slow, asynchronous square wave, counted in clk_in cycles.
// One measurement is published per rise-to-rise interval, with a one-cycle valid and a timeout level.
module medidor_periodo #(
   parameter int N       = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic         clk_in,
   input  logic         reset,
   input  logic         sig_in,
   input  logic         enable,
   output logic [N-1:0] periodo,
   output logic [N-1:0] alto,
   output logic         valid,
   output logic         timeout
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ARMED   = 2'd1;
   localparam logic [1:0] MEASURE = 2'd2;

   localparam logic [N-1:0] CNT_ONE     = N'(1);
   localparam logic [N-1:0] TIMEOUT_CNT = N'(TIMEOUT);

   logic [1:0]   state;
   logic [N-1:0] cnt;
   logic [N-1:0] alto_sh;
   logic         s1, s2, s3;
   logic         rise, fall;

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

   // The synchronizer runs regardless of enable so re-enabling never fakes a rise.
   always_ff @(posedge clk_in) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         alto_sh <= '0;
         periodo <= '0;
         alto    <= '0;
         valid   <= 1'b0;
         timeout <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (!enable) begin
            state   <= IDLE;
            cnt     <= '0;
            alto_sh <= '0;
         end else begin
            case (state)
               IDLE: begin
                  cnt   <= '0;
                  state <= ARMED;
               end
               ARMED: begin
                  if (rise) begin
                     cnt   <= CNT_ONE;
                     state <= MEASURE;
                  end
               end
               MEASURE: begin
                  // A rise on the timeout cycle still counts as a normal capture.
                  if (rise) begin
                     periodo <= cnt;
                     alto    <= alto_sh;
                     valid   <= 1'b1;
                     timeout <= 1'b0;
                     cnt     <= CNT_ONE;
                  end else if (cnt == TIMEOUT_CNT) begin
                     timeout <= 1'b1;
                     periodo <= '0;
                     alto    <= '0;
                     cnt     <= '0;
                     state   <= ARMED;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
                  if (fall) begin
                     alto_sh <= cnt;
                  end
               end
               default: begin
                  cnt   <= '0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
